pwm_deadtime_gen: RTL and testbench
===================================

PWM_DEADTIME_GEN -- requirements
Module: pwm_deadtime_gen

Interface
REQ-001 The block SHALL have parameter DT_W, default 8, giving the width of the dead-time count.
REQ-002 clk  input  1  single system clock; all logic SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  high = gate drive permitted; low = both gates off.
REQ-005 pwm_in  input  1  unipolar PWM command from the PWM comparator stage (1 = high side, 0 = low side).
REQ-006 dead_cycles  input  DT_W  dead-time length in clk cycles, unsigned.
REQ-007 trip  input  1  fault request; forces both gates off.
REQ-008 trip_clr  input  1  clears a latched trip.
REQ-009 gate_hi  output  1  registered high-side gate drive.
REQ-010 gate_lo  output  1  registered low-side gate drive.
REQ-011 dt_active  output  1  high while a dead interval is being counted.
REQ-012 fault  output  1  high while the trip is latched.

Function
REQ-013 pwm_in SHALL be registered once (pwm_q) before use; the FSM SHALL act only on pwm_q.
REQ-014 FSM states: IDLE, HI_ON, LO_ON, DEAD, TRIPPED; all outputs SHALL be registered.
REQ-015 gate_hi and gate_lo SHALL never be high in the same cycle, under any input sequence.
REQ-016 Effective dead time D SHALL be max(dead_cycles, 1); a direct HI_ON<->LO_ON transition is forbidden.
REQ-017 dead_cycles SHALL be sampled only on entry to DEAD; changes during DEAD SHALL NOT affect the current interval.
REQ-018 Entry to DEAD from IDLE: when enable=1, the FSM SHALL enter DEAD.
REQ-019 Entry to DEAD from HI_ON or LO_ON: when pwm_q disagrees with the on-side, the FSM SHALL enter DEAD.
REQ-020 Gate timing: if pwm_q changes at edge k, the active gate SHALL fall at edge k+1, and dt_active SHALL be high from edge k+1 for D cycles.
REQ-021 At the end of DEAD, the FSM SHALL enter HI_ON if pwm_q=1 and LO_ON if pwm_q=0, using pwm_q at that edge.
REQ-022 The entered gate SHALL rise at edge k+1+D; if pwm_q has reverted, the same side SHALL re-enable after the full D.
REQ-023 pwm_q toggling during DEAD SHALL neither restart nor shorten the interval.
REQ-024 enable=0 in any state except TRIPPED SHALL send the FSM to IDLE, with both gates low at the next edge.
REQ-025 enable=0 SHALL NOT be sticky.
REQ-026 trip=1 in any state SHALL send the FSM to TRIPPED, with both gates low and fault=1 at the next edge.
REQ-027 trip SHALL have priority over enable, trip_clr and the dead-time count.
REQ-028 TRIPPED SHALL exit to IDLE only when trip_clr=1 and trip=0 in the same cycle; if trip and trip_clr are both high, the FSM SHALL remain in TRIPPED.
REQ-029 fault SHALL fall on exit from TRIPPED.
REQ-030 The dead-time counter SHALL saturate at zero and never wrap.

Reset
REQ-031 reset SHALL force, at the next edge: state IDLE, pwm_q=0, counter=0, gate_hi=0, gate_lo=0, dt_active=0, fault=0.
REQ-032 reset SHALL have priority over trip, and reset mid-DEAD SHALL abandon the interval.
REQ-033 After reset, a latched trip SHALL be cleared.

Structure
REQ-034 The FSM state enumeration and the DT_W default SHALL be defined in the shared package pwm_pkg.
REQ-035 The dead-time counter SHALL be a sub-module, deadtime_counter (load, count-down, done flag).

Verification
REQ-036 Scenario 1: enable=1, dead_cycles=5, pwm_in 0->1 -> gate_lo falls at k+1, dt_active is high for 5 cycles, gate_hi rises at k+6.
REQ-037 Scenario 2: dead_cycles=0, toggle pwm_in -> one dead cycle occurs; gates are never both high.
REQ-038 Scenario 3: dead_cycles=10, pwm_in pulses high for 3 cycles during LO_ON -> DEAD lasts the full 10 cycles, then gate_lo returns; gate_hi never pulses.
REQ-039 Scenario 4: trip during HI_ON -> both gates are 0 and fault=1 at the next edge.
REQ-040 Scenario 5: after the Scenario 4 trip, trip+trip_clr asserted together -> the FSM stays TRIPPED; trip_clr alone -> IDLE, then DEAD, then the gate selected by pwm_q.
REQ-041 Scenario 6: reset asserted mid-DEAD with dead_cycles=200 -> all outputs are 0 at the next edge.
REQ-042 Scenario 7: random pwm_in/dead_cycles/enable run -> an assertion confirms gate_hi&gate_lo is never 1.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the dead-time PWM gate driver: FSM states and
// the default width of the dead-time count.
package pwm_pkg;

    localparam int DT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HI_ON   = 3'd1,
        ST_LO_ON   = 3'd2,
        ST_DEAD    = 3'd3,
        ST_TRIPPED = 3'd4
    } pwm_state_e;

endpackage

// File: rtl/deadtime_counter.sv
// Dead-time down-counter: loaded on entry to the dead interval, counts down
// once per cycle, and flags done on the last cycle of the interval.
module deadtime_counter #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            load,
    input  logic [DT_W-1:0] load_val,
    input  logic            dec,
    output logic            done
);

    logic [DT_W-1:0] count_q;
    logic [DT_W-1:0] count_d;

    // Next count: clear beats load beats decrement; decrement stops at zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - DT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A count of one means the current cycle is the last dead cycle.
    assign done = (count_q <= DT_W'(1));

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary gate driver with programmable dead time, enable gating and
// a latched trip. Every output comes straight from a register.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_cycles,
    input  logic            trip,
    input  logic            trip_clr,
    output logic            gate_hi,
    output logic            gate_lo,
    output logic            dt_active,
    output logic            fault
);

    pwm_state_e      state_q;
    logic            pwm_q;
    logic            gate_hi_q;
    logic            gate_lo_q;
    logic            dt_active_q;
    logic            fault_q;

    logic            go_dead;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_clr;
    logic            cnt_done;
    logic [DT_W-1:0] dead_eff;

    // Register the PWM command; the FSM only ever looks at pwm_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_in;
        end
    end

    // Counter control: load on entry to DEAD, count while in DEAD, clear on
    // any exit so the counter idles at zero.
    always_comb begin
        dead_eff = (dead_cycles == '0) ? DT_W'(1) : dead_cycles;
        go_dead  = !trip && enable &&
                   ((state_q == ST_IDLE) ||
                    ((state_q == ST_HI_ON) && !pwm_q) ||
                    ((state_q == ST_LO_ON) &&  pwm_q));
        cnt_load = go_dead;
        cnt_dec  = (state_q == ST_DEAD) && !trip && enable && !cnt_done;
        cnt_clr  = (state_q == ST_DEAD) && (trip || !enable || cnt_done);
    end

    deadtime_counter #(
        .DT_W (DT_W)
    ) u_deadtime_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (dead_eff),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    // Gate FSM: reset > trip > enable > dead-time sequencing. Outputs are
    // written alongside the state so they line up with it exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gate_hi_q   <= 1'b0;
            gate_lo_q   <= 1'b0;
            dt_active_q <= 1'b0;
            fault_q     <= 1'b0;
        end else if (trip) begin
            state_q     <= ST_TRIPPED;
            gate_hi_q   <= 1'b0;
            gate_lo_q   <= 1'b0;
            dt_active_q <= 1'b0;
            fault_q     <= 1'b1;
        end else if (state_q == ST_TRIPPED) begin
            // Stays latched until a clear arrives with trip low.
            gate_hi_q   <= 1'b0;
            gate_lo_q   <= 1'b0;
            dt_active_q <= 1'b0;
            if (trip_clr) begin
                state_q <= ST_IDLE;
                fault_q <= 1'b0;
            end else begin
                fault_q <= 1'b1;
            end
        end else if (!enable) begin
            state_q     <= ST_IDLE;
            gate_hi_q   <= 1'b0;
            gate_lo_q   <= 1'b0;
            dt_active_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q     <= ST_DEAD;
                    gate_hi_q   <= 1'b0;
                    gate_lo_q   <= 1'b0;
                    dt_active_q <= 1'b1;
                end
                ST_HI_ON: begin
                    if (!pwm_q) begin
                        state_q     <= ST_DEAD;
                        gate_hi_q   <= 1'b0;
                        dt_active_q <= 1'b1;
                    end
                end
                ST_LO_ON: begin
                    if (pwm_q) begin
                        state_q     <= ST_DEAD;
                        gate_lo_q   <= 1'b0;
                        dt_active_q <= 1'b1;
                    end
                end
                ST_DEAD: begin
                    // Side is chosen from pwm_q at the closing edge only, so
                    // a reverted command just re-enables the same side.
                    if (cnt_done) begin
                        dt_active_q <= 1'b0;
                        if (pwm_q) begin
                            state_q   <= ST_HI_ON;
                            gate_hi_q <= 1'b1;
                            gate_lo_q <= 1'b0;
                        end else begin
                            state_q   <= ST_LO_ON;
                            gate_hi_q <= 1'b0;
                            gate_lo_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    gate_hi_q   <= 1'b0;
                    gate_lo_q   <= 1'b0;
                    dt_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign gate_hi   = gate_hi_q;
    assign gate_lo   = gate_lo_q;
    assign dt_active = dt_active_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: dead-time timing, zero dead time,
// reverted command, enable, trip latch/clear, reset mid-interval, random run.
module tb_pwm_deadtime_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pwm_in;
    logic [7:0] dead_cycles;
    logic       trip;
    logic       trip_clr;
    logic       gate_hi;
    logic       gate_lo;
    logic       dt_active;
    logic       fault;

    int checks = 0;
    int errors = 0;

    pwm_deadtime_gen #(
        .DT_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pwm_in      (pwm_in),
        .dead_cycles (dead_cycles),
        .trip        (trip),
        .trip_clr    (trip_clr),
        .gate_hi     (gate_hi),
        .gate_lo     (gate_lo),
        .dt_active   (dt_active),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Shoot-through guard on every cycle.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            assert (!(gate_hi === 1'b1 && gate_lo === 1'b1)) else begin
                errors++;
                $display("FAIL gate_overlap at %0t: gate_hi=%b gate_lo=%b required not both 1",
                         $time, gate_hi, gate_lo);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; pwm_in = 1'b0; dead_cycles = 8'd5;
        trip = 1'b1; trip_clr = 1'b0;
        tick; tick;
        checks++;
        if ({gate_hi, gate_lo, dt_active, fault} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000", {gate_hi, gate_lo, dt_active, fault});
        end
        reset = 1'b0; trip = 1'b0;
    endtask

    // Enable from IDLE goes through one full dead interval to the low side.
    task automatic test_startup;
        enable = 1'b1;
        tick;
        checks++;
        if ({gate_hi, gate_lo, dt_active} !== 3'b001) begin
            errors++;
            $display("FAIL startup_dead got=%b exp=001", {gate_hi, gate_lo, dt_active});
        end
        repeat (4) tick;
        checks++;
        if ({gate_hi, gate_lo, dt_active} !== 3'b001) begin
            errors++;
            $display("FAIL startup_dead_last got=%b exp=001", {gate_hi, gate_lo, dt_active});
        end
        tick;
        checks++;
        if ({gate_hi, gate_lo, dt_active} !== 3'b010) begin
            errors++;
            $display("FAIL startup_lo_on got=%b exp=010", {gate_hi, gate_lo, dt_active});
        end
    endtask

    // dead_cycles=5, pwm 0->1: lo falls at k+1, 5 dead cycles, hi at k+6.
    task automatic test_deadtime;
        logic [2:0] exp_seq [7] = '{3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b100};
        pwm_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick;
            checks++;
            if ({gate_hi, gate_lo, dt_active} !== exp_seq[i]) begin
                errors++;
                $display("FAIL deadtime_5 step=%0d got=%b exp=%b", i, {gate_hi, gate_lo, dt_active}, exp_seq[i]);
            end
        end
    endtask

    // dead_cycles=0 behaves as exactly one dead cycle in each direction.
    task automatic test_zero_dead;
        logic       pv      [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0] exp_seq [6] = '{3'b100, 3'b001, 3'b010, 3'b010, 3'b001, 3'b100};
        dead_cycles = 8'd0;
        for (int i = 0; i < 6; i++) begin
            pwm_in = pv[i];
            tick;
            checks++;
            if ({gate_hi, gate_lo, dt_active} !== exp_seq[i]) begin
                errors++;
                $display("FAIL zero_dead step=%0d got=%b exp=%b", i, {gate_hi, gate_lo, dt_active}, exp_seq[i]);
            end
        end
    endtask

    // 3-cycle high pulse from LO_ON with D=10: full interval, lo returns,
    // and a mid-interval dead_cycles change is ignored.
    task automatic test_reverted_pulse;
        pwm_in = 1'b0;
        repeat (3) tick;
        checks++;
        if ({gate_hi, gate_lo, dt_active} !== 3'b010) begin
            errors++;
            $display("FAIL pulse_setup got=%b exp=010", {gate_hi, gate_lo, dt_active});
        end
        dead_cycles = 8'd10;
        for (int i = 0; i < 12; i++) begin
            pwm_in = (i < 3);
            if (i == 2) dead_cycles = 8'd2;
            tick;
            checks++;
            if ({gate_hi, gate_lo, dt_active} !== ((i == 0 || i == 11) ? 3'b010 : 3'b001)) begin
                errors++;
                $display("FAIL pulse_dead step=%0d got=%b exp=%b", i, {gate_hi, gate_lo, dt_active},
                         ((i == 0 || i == 11) ? 3'b010 : 3'b001));
            end
        end
    endtask

    // enable low kills both gates next edge and is not sticky.
    task automatic test_enable;
        logic       ev      [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0] exp_seq [5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010};
        for (int i = 0; i < 5; i++) begin
            enable = ev[i];
            tick;
            checks++;
            if ({gate_hi, gate_lo, dt_active} !== exp_seq[i]) begin
                errors++;
                $display("FAIL enable step=%0d got=%b exp=%b", i, {gate_hi, gate_lo, dt_active}, exp_seq[i]);
            end
        end
    endtask

    // Trip during HI_ON: both gates off, fault high at the next edge.
    task automatic test_trip;
        dead_cycles = 8'd3;
        pwm_in = 1'b1;
        repeat (5) tick;
        checks++;
        if ({gate_hi, gate_lo, dt_active} !== 3'b100) begin
            errors++;
            $display("FAIL trip_setup got=%b exp=100", {gate_hi, gate_lo, dt_active});
        end
        trip = 1'b1;
        tick;
        checks++;
        if ({gate_hi, gate_lo, dt_active, fault} !== 4'b0001) begin
            errors++;
            $display("FAIL trip_hi_on got=%b exp=0001", {gate_hi, gate_lo, dt_active, fault});
        end
    endtask

    // trip+trip_clr holds TRIPPED; trip_clr alone -> IDLE -> DEAD -> hi.
    task automatic test_trip_clear;
        logic [3:0] exp_seq [6] = '{4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
        for (int i = 0; i < 6; i++) begin
            trip     = (i == 0);
            trip_clr = (i < 2);
            tick;
            checks++;
            if ({gate_hi, gate_lo, dt_active, fault} !== exp_seq[i]) begin
                errors++;
                $display("FAIL trip_clear step=%0d got=%b exp=%b", i, {gate_hi, gate_lo, dt_active, fault}, exp_seq[i]);
            end
        end
    endtask

    // Reset (together with trip) mid-DEAD at D=200 zeroes everything.
    task automatic test_reset_mid_dead;
        dead_cycles = 8'd200;
        pwm_in = 1'b0;
        repeat (5) tick;
        checks++;
        if ({gate_hi, gate_lo, dt_active} !== 3'b001) begin
            errors++;
            $display("FAIL long_dead got=%b exp=001", {gate_hi, gate_lo, dt_active});
        end
        reset = 1'b1; trip = 1'b1;
        tick;
        checks++;
        if ({gate_hi, gate_lo, dt_active, fault} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_dead got=%b exp=0000", {gate_hi, gate_lo, dt_active, fault});
        end
        reset = 1'b0; trip = 1'b0;
        tick;
        checks++;
        if ({gate_hi, gate_lo, dt_active, fault} !== 4'b0010) begin
            errors++;
            $display("FAIL after_reset_restart got=%b exp=0010", {gate_hi, gate_lo, dt_active, fault});
        end
    endtask

    // Random run: gates never both high, and no gate high during dead time.
    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            pwm_in      = 1'($urandom_range(0, 1));
            dead_cycles = 8'($urandom_range(0, 7));
            enable      = ($urandom_range(0, 15) != 0);
            trip        = ($urandom_range(0, 99) == 0);
            trip_clr    = ($urandom_range(0, 3) == 0);
            tick;
            checks++;
            if ((gate_hi & gate_lo) !== 1'b0 || (dt_active & (gate_hi | gate_lo)) !== 1'b0) begin
                errors++;
                $display("FAIL random_invariant cycle=%0d got hi/lo/dt=%b exp no overlap",
                         i, {gate_hi, gate_lo, dt_active});
            end
        end
        trip = 1'b0; trip_clr = 1'b0;
    endtask

    initial begin
        test_reset;
        test_startup;
        test_deadtime;
        test_zero_dead;
        test_reverted_pulse;
        test_enable;
        test_trip;
        test_trip_clear;
        test_reset_mid_dead;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
